// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUCtrl codes, aluop encodings, issue FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational {aluop, funct3, funct7[5]} -> ALUCtrl decoder with illegal flag.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [2:0] i_funct3,
  input  logic       i_f7b5,
  output logic [3:0] o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = ALU_AND;
    o_illegal = 1'b0;
    unique case (i_aluop)
      OP_ADD: o_ctrl = ALU_ADD;
      OP_BR: begin
        o_ctrl = ALU_SUB;
        if (i_funct3[2:1] != 2'b00)
          o_illegal = 1'b1;
      end
      OP_R: begin
        unique case (i_funct3)
          3'b000:  o_ctrl = i_f7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  o_ctrl = ALU_AND;
          3'b110:  o_ctrl = ALU_OR;
          default: o_illegal = 1'b1;
        endcase
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: request handshake, registered operands, response capture.
// Optional perf counters enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_aluop,
  input  logic [2:0]       in_funct3,
  input  logic             in_f7b5,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_y,
  input  logic             alu_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_y,
  output logic             res_zero,
  output logic             res_taken,
  output logic             res_illegal,
  output logic [TAG_W-1:0] res_tag
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_illegal
`endif
);

  state_t r_state;
  state_t w_next;

  logic [3:0]       w_ctrl;
  logic             w_ill;
  logic             w_accept;
  logic             w_retire;
  logic             w_taken;

  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [3:0]       r_ctrl;
  logic [TAG_W-1:0] r_tag;
  logic             r_ill;
  logic             r_br;
  logic             r_bne;

  logic [31:0]      r_y;
  logic             r_zero;
  logic             r_taken;
  logic             r_res_ill;
  logic [TAG_W-1:0] r_res_tag;

  alu_ctrl_dec u_dec (
    .i_aluop   (in_aluop),
    .i_funct3  (in_funct3),
    .i_f7b5    (in_f7b5),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (in_valid) w_next = EXEC;
      EXEC: w_next = RESP;
      RESP: if (res_ready) w_next = in_valid ? EXEC : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) || (r_state == RESP && res_ready);
    res_valid = (r_state == RESP);
  end

  assign w_accept = in_valid && in_ready;
  assign w_retire = res_valid && res_ready;
  // Only well-formed branches can be taken; funct3[0] selects BNE.
  assign w_taken  = r_br && (r_bne ? !alu_zero : alu_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_ctrl    <= ALU_AND;
      r_tag     <= '0;
      r_ill     <= 1'b0;
      r_br      <= 1'b0;
      r_bne     <= 1'b0;
      r_y       <= '0;
      r_zero    <= 1'b0;
      r_taken   <= 1'b0;
      r_res_ill <= 1'b0;
      r_res_tag <= '0;
    end else begin
      if (w_accept) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_ctrl <= w_ctrl;
        r_tag  <= in_tag;
        r_ill  <= w_ill;
        r_br   <= (in_aluop == OP_BR) && !w_ill;
        r_bne  <= in_funct3[0];
      end
      if (r_state == EXEC) begin
        r_y       <= r_ill ? 32'd0 : alu_y;
        r_zero    <= alu_zero;
        r_taken   <= w_taken;
        r_res_ill <= r_ill;
        r_res_tag <= r_tag;
      end
    end
  end

  assign alu_a       = r_a;
  assign alu_b       = r_b;
  assign alu_ctrl    = r_ctrl;
  assign res_y       = r_y;
  assign res_zero    = r_zero;
  assign res_taken   = r_taken;
  assign res_illegal = r_res_ill;
  assign res_tag     = r_res_tag;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_ops;
  logic [31:0] r_perf_ill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_ops <= '0;
      r_perf_ill <= '0;
    end else if (w_retire) begin
      r_perf_ops <= r_perf_ops + 32'd1;
      if (r_res_ill)
        r_perf_ill <= r_perf_ill + 32'd1;
    end
  end

  assign perf_ops     = r_perf_ops;
  assign perf_illegal = r_perf_ill;
`else
  logic w_unused;
  assign w_unused = w_retire;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_aluop;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_y;
  logic        alu_zero;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_y;
  logic        res_zero;
  logic        res_taken;
  logic        res_illegal;
  logic [4:0]  res_tag;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops;
  logic [31:0] perf_illegal;
`endif

  int n_chk = 0;
  int n_err = 0;
  int exp_ops = 0;
  int exp_ill = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.TAG_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_aluop    (in_aluop),
    .in_funct3   (in_funct3),
    .in_f7b5     (in_f7b5),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_tag      (in_tag),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_y       (alu_y),
    .alu_zero    (alu_zero),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_y       (res_y),
    .res_zero    (res_zero),
    .res_taken   (res_taken),
    .res_illegal (res_illegal),
    .res_tag     (res_tag)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_ops    (perf_ops),
    .perf_illegal(perf_illegal)
`endif
  );

  always_comb begin
    case (alu_ctrl)
      4'b0000: alu_y = alu_a & alu_b;
      4'b0001: alu_y = alu_a | alu_b;
      4'b0010: alu_y = alu_a + alu_b;
      4'b0110: alu_y = alu_a - alu_b;
      default: alu_y = 32'd0;
    endcase
    alu_zero = (alu_y == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3,
                       input logic f7, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    in_aluop  = op;
    in_funct3 = f3;
    in_f7b5   = f7;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    in_valid  = 1'b1;
  endtask

  task automatic chk_zero_state(input string tag);
    check({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".alu_a"}, alu_a, 32'd0);
    check({tag, ".alu_b"}, alu_b, 32'd0);
    check({tag, ".alu_ctrl"}, 32'(alu_ctrl), 32'd0);
    check({tag, ".res_y"}, res_y, 32'd0);
    check({tag, ".res_zero"}, 32'(res_zero), 32'd0);
    check({tag, ".res_taken"}, 32'(res_taken), 32'd0);
    check({tag, ".res_illegal"}, 32'(res_illegal), 32'd0);
    check({tag, ".res_tag"}, 32'(res_tag), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    check({tag, ".perf_ops"}, perf_ops, 32'd0);
    check({tag, ".perf_illegal"}, perf_illegal, 32'd0);
`endif
  endtask

  // Entered idle with res_ready=1; leaves idle after the retire edge.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, input logic [3:0] ectl,
                        input logic [31:0] ey, input logic ez,
                        input logic et, input logic ei);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    drive(op, f3, f7, a, b, t);
    tick();
    in_valid = 1'b0;
    check({tag, ".ctrl"}, 32'(alu_ctrl), 32'(ectl));
    check({tag, ".alu_a"}, alu_a, a);
    check({tag, ".exec_valid"}, 32'(res_valid), 32'd0);
    tick();
    check({tag, ".res_valid"}, 32'(res_valid), 32'd1);
    check({tag, ".y"}, res_y, ey);
    check({tag, ".zero"}, 32'(res_zero), 32'(ez));
    check({tag, ".taken"}, 32'(res_taken), 32'(et));
    check({tag, ".illegal"}, 32'(res_illegal), 32'(ei));
    check({tag, ".tag"}, 32'(res_tag), 32'(t));
    tick();
    exp_ops++;
    if (ei) exp_ill++;
    check({tag, ".retired"}, 32'(res_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_aluop = 2'b00;
    in_funct3 = 3'b000;
    in_f7b5 = 1'b0;
    in_a = '0;
    in_b = '0;
    in_tag = '0;
    res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_zero_state("reset");

    run_op("add", 2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 5'd3,
           4'b0010, 32'd12, 1'b0, 1'b0, 1'b0);
    run_op("sub", 2'b10, 3'b000, 1'b1, 32'd9, 32'd9, 5'd4,
           4'b0110, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op("and", 2'b10, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00,
           5'd5, 4'b0000, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    run_op("or", 2'b10, 3'b110, 1'b0, 32'h0000_0F00, 32'h0000_00F0,
           5'd6, 4'b0001, 32'h0000_0FF0, 1'b0, 1'b0, 1'b0);
    run_op("beq", 2'b01, 3'b000, 1'b0, 32'd4, 32'd4, 5'd7,
           4'b0110, 32'd0, 1'b1, 1'b1, 1'b0);
    run_op("bne_eq", 2'b01, 3'b001, 1'b0, 32'd4, 32'd4, 5'd8,
           4'b0110, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op("bne_ne", 2'b01, 3'b001, 1'b0, 32'hFFFF_FFFF, 32'd0, 5'd9,
           4'b0110, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("add_wrap", 2'b00, 3'b101, 1'b1, 32'hFFFF_FFFF, 32'd1,
           5'd10, 4'b0010, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op("ill_r", 2'b10, 3'b001, 1'b0, 32'd3, 32'd5, 5'd11,
           4'b0000, 32'd0, 1'b0, 1'b0, 1'b1);
    run_op("ill_11", 2'b11, 3'b000, 1'b0, 32'd0, 32'd0, 5'd12,
           4'b0000, 32'd0, 1'b1, 1'b0, 1'b1);
    run_op("ill_br", 2'b01, 3'b010, 1'b0, 32'd4, 32'd4, 5'd13,
           4'b0110, 32'd0, 1'b1, 1'b0, 1'b1);
`ifdef ALU_ISSUE_PERF_EN
    check("perf_ops", perf_ops, 32'(exp_ops));
    check("perf_illegal", perf_illegal, 32'(exp_ill));
`endif

    // Backpressure, then retire and accept on the same edge.
    res_ready = 1'b0;
    drive(2'b10, 3'b000, 1'b0, 32'd1, 32'd2, 5'd17);
    tick();
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 32'(res_valid), 32'd1);
      check("bp.y", res_y, 32'd3);
      check("bp.tag", 32'(res_tag), 32'd17);
      check("bp.in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    drive(2'b10, 3'b000, 1'b1, 32'd10, 32'd3, 5'd19);
    res_ready = 1'b1;
    #1;
    check("bb.in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("bb.valid", 32'(res_valid), 32'd0);
    check("bb.alu_a", alu_a, 32'd10);
    check("bb.ctrl", 32'(alu_ctrl), 32'd6);
    tick();
    check("bb.valid2", 32'(res_valid), 32'd1);
    check("bb.y", res_y, 32'd7);
    check("bb.tag", 32'(res_tag), 32'd19);
    tick();
    exp_ops += 2;
`ifdef ALU_ISSUE_PERF_EN
    check("bb.perf_ops", perf_ops, 32'(exp_ops));
`endif

    // Reset while in EXEC.
    drive(2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 5'd3);
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero_state("rst_exec");

    // Reset while holding an illegal response.
    res_ready = 1'b0;
    drive(2'b11, 3'b000, 1'b0, 32'd0, 32'd0, 5'd31);
    tick();
    in_valid = 1'b0;
    tick();
    check("rr.valid", 32'(res_valid), 32'd1);
    check("rr.illegal", 32'(res_illegal), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    res_ready = 1'b1;
    chk_zero_state("rst_resp");

    run_op("post_rst", 2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 5'd3,
           4'b0010, 32'd12, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
